// File: rtl/tlights_pkg.sv
// Shared types for the two-way junction controller.
// PED_CROSSING_EN adds the pedestrian walk/clear states.
package tlights_pkg;

    typedef logic [2:0] rag_t;

    localparam rag_t RAG_RED    = 3'b100;
    localparam rag_t RAG_REDAMB = 3'b110;
    localparam rag_t RAG_GREEN  = 3'b001;
    localparam rag_t RAG_AMBER  = 3'b010;

    typedef enum logic [3:0] {
        ALLRED_B,
        NS_REDAMB,
        NS_GREEN,
        NS_AMBER,
        ALLRED_A,
        EW_REDAMB,
        EW_GREEN,
        EW_AMBER
`ifdef PED_CROSSING_EN
        ,
        PED_WALK,
        PED_CLEAR
`endif
    } jstate_t;

endpackage

// File: rtl/tlights_phase_timer.sv
// Down-counter timing the fixed-length junction phases.
// done_o is high while the count sits at zero.
module tlights_phase_timer #(
    parameter int TW      = 5,
    parameter int RST_VAL = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic [TW-1:0] val_i,
    output logic          done_o
);

    logic [TW-1:0] cnt_q;

    // Load on phase entry, otherwise count down and park at zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= TW'(RST_VAL);
        end else if (load_i) begin
            cnt_q <= val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/tlights_junction_ctrl.sv
// Moore sequencer granting a two-way junction to NS or EW.
// Optional pedestrian phase enabled by PED_CROSSING_EN.
module tlights_junction_ctrl
    import tlights_pkg::*;
#(
    parameter int GREEN_MIN = 8,
    parameter int GREEN_MAX = 20,
    parameter int AMBER_T   = 3,
    parameter int REDAMB_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 6,
    parameter int TW        = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_ns,
    input  logic       req_ew,
    input  logic       ped_req,
    output logic [2:0] rag_ns,
    output logic [2:0] rag_ew,
    output logic       walk
);

    localparam int EW_W = $clog2(GREEN_MAX + 1);
    localparam logic [EW_W-1:0] E_MIN = EW_W'(GREEN_MIN - 1);
    localparam logic [EW_W-1:0] E_MAX = EW_W'(GREEN_MAX - 1);

    jstate_t         state_q, state_d;
    logic [EW_W-1:0] e_q;
    logic            dem_ns_q, dem_ns_d;
    logic            dem_ew_q, dem_ew_d;
    logic            ped_opp;
    logic            tmr_load;
    logic [TW-1:0]   tmr_val;
    logic            tmr_done;
    logic            go_ns, go_ew;

`ifdef PED_CROSSING_EN
    logic dem_ped_q, dem_ped_d;
    logic nxt_ew_q, nxt_ew_d;
    logic walk_c;

    assign ped_opp = dem_ped_q;
    assign walk    = walk_c;
`else
    logic [TW:0] ped_unused;

    assign ped_opp    = 1'b0;
    assign walk       = 1'b0;
    assign ped_unused = {ped_req, TW'(WALK_T - 1)};
`endif

    // Green may hand over once minimum served and the other side waits
    assign go_ns = (e_q >= E_MIN) && (dem_ew_q || ped_opp)
                 && (!req_ns || (e_q >= E_MAX));
    assign go_ew = (e_q >= E_MIN) && (dem_ns_q || ped_opp)
                 && (!req_ew || (e_q >= E_MAX));

    tlights_phase_timer #(
        .TW      (TW),
        .RST_VAL (ALLRED_T - 1)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (tmr_load),
        .val_i  (tmr_val),
        .done_o (tmr_done)
    );

    // Next-state and lamp decode from the state register only
    always_comb begin
        state_d = state_q;
        rag_ns  = RAG_RED;
        rag_ew  = RAG_RED;
`ifdef PED_CROSSING_EN
        walk_c  = 1'b0;
`endif
        unique case (state_q)
            ALLRED_B: begin
                if (tmr_done) begin
                    state_d = NS_REDAMB;
`ifdef PED_CROSSING_EN
                    if (dem_ped_q) state_d = PED_WALK;
`endif
                end
            end
            NS_REDAMB: begin
                rag_ns = RAG_REDAMB;
                if (tmr_done) state_d = NS_GREEN;
            end
            NS_GREEN: begin
                rag_ns = RAG_GREEN;
                if (go_ns) state_d = NS_AMBER;
            end
            NS_AMBER: begin
                rag_ns = RAG_AMBER;
                if (tmr_done) state_d = ALLRED_A;
            end
            ALLRED_A: begin
                if (tmr_done) begin
                    state_d = EW_REDAMB;
`ifdef PED_CROSSING_EN
                    if (dem_ped_q) state_d = PED_WALK;
`endif
                end
            end
            EW_REDAMB: begin
                rag_ew = RAG_REDAMB;
                if (tmr_done) state_d = EW_GREEN;
            end
            EW_GREEN: begin
                rag_ew = RAG_GREEN;
                if (go_ew) state_d = EW_AMBER;
            end
            EW_AMBER: begin
                rag_ew = RAG_AMBER;
                if (tmr_done) state_d = ALLRED_B;
            end
`ifdef PED_CROSSING_EN
            PED_WALK: begin
                walk_c = 1'b1;
                if (tmr_done) state_d = PED_CLEAR;
            end
            PED_CLEAR: begin
                if (tmr_done) begin
                    state_d = nxt_ew_q ? EW_REDAMB : NS_REDAMB;
                end
            end
`endif
            default: state_d = ALLRED_B;
        endcase
    end

    // Phase duration loaded into the timer on every state change
    always_comb begin
        tmr_load = (state_d != state_q);
        tmr_val  = '0;
        unique case (state_d)
            NS_REDAMB, EW_REDAMB: tmr_val = TW'(REDAMB_T - 1);
            NS_AMBER, EW_AMBER:   tmr_val = TW'(AMBER_T - 1);
            ALLRED_A, ALLRED_B:   tmr_val = TW'(ALLRED_T - 1);
`ifdef PED_CROSSING_EN
            PED_WALK:             tmr_val = TW'(WALK_T - 1);
            PED_CLEAR:            tmr_val = TW'(ALLRED_T - 1);
`endif
            default:              tmr_val = '0;
        endcase
    end

    // Demand latches: new request beats the clear on REDAMB entry
    always_comb begin
        dem_ns_d = req_ns
                 | (dem_ns_q & ~(tmr_load && (state_d == NS_REDAMB)));
        dem_ew_d = req_ew
                 | (dem_ew_q & ~(tmr_load && (state_d == EW_REDAMB)));
    end

    // State, green elapsed counter and vehicle demand registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ALLRED_B;
            e_q      <= '0;
            dem_ns_q <= 1'b0;
            dem_ew_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dem_ns_q <= dem_ns_d;
            dem_ew_q <= dem_ew_d;
            if (tmr_load) begin
                e_q <= '0;
            end else if (e_q != E_MAX) begin
                e_q <= e_q + 1'b1;
            end
        end
    end

`ifdef PED_CROSSING_EN
    // Pedestrian demand and which REDAMB the walk phase displaced
    always_comb begin
        dem_ped_d = ped_req
                  | (dem_ped_q & ~(tmr_load && (state_d == PED_WALK)));
        nxt_ew_d  = nxt_ew_q;
        if (tmr_load && (state_d == PED_WALK)) begin
            nxt_ew_d = (state_q == ALLRED_A);
        end
    end

    // Pedestrian registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dem_ped_q <= 1'b0;
            nxt_ew_q  <= 1'b0;
        end else begin
            dem_ped_q <= dem_ped_d;
            nxt_ew_q  <= nxt_ew_d;
        end
    end
`endif

endmodule

// File: tb/tb_tlights_junction_ctrl.sv
// Self-checking bench for tlights_junction_ctrl.
// Vector table, directed corner cases, random run vs phase model.
module tb_tlights_junction_ctrl;

    localparam int GMIN = 8;
    localparam int GMAX = 20;
    localparam int AMB  = 3;
    localparam int RA   = 2;
    localparam int AR   = 1;
    localparam int WK   = 6;
`ifdef PED_CROSSING_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif

    localparam logic [2:0] R  = 3'b100;
    localparam logic [2:0] RY = 3'b110;
    localparam logic [2:0] G  = 3'b001;
    localparam logic [2:0] Y  = 3'b010;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_ns = 1'b0;
    logic       req_ew = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] rag_ns, rag_ew;
    logic       walk;

    int total = 0;
    int bad   = 0;

    tlights_junction_ctrl #(
        .GREEN_MIN (GMIN),
        .GREEN_MAX (GMAX),
        .AMBER_T   (AMB),
        .REDAMB_T  (RA),
        .ALLRED_T  (AR),
        .WALK_T    (WK),
        .TW        (5)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_ns  (req_ns),
        .req_ew  (req_ew),
        .ped_req (ped_req),
        .rag_ns  (rag_ns),
        .rag_ew  (rag_ew),
        .walk    (walk)
    );

    always #5 clk = ~clk;

    // Phase model: 0..7 follow the fixed ring, 8 walk, 9 ped clear
    int mp = 0;
    int mn = 0;
    int mnxt = 1;
    bit mdns = 0, mdew = 0, mdped = 0;

    function automatic int dur_of(int p);
        case (p)
            1, 5:    return RA;
            3, 7:    return AMB;
            8:       return WK;
            default: return AR;
        endcase
    endfunction

    task automatic model_step();
        int np;
        bit ex, own, opp;
        if (!rst_n) begin
            mp = 0; mn = 0; mnxt = 1;
            mdns = 0; mdew = 0; mdped = 0;
            return;
        end
        if (mp == 2 || mp == 6) begin
            own = (mp == 2) ? req_ns : req_ew;
            opp = ((mp == 2) ? mdew : mdns) | mdped;
            ex  = (mn >= GMIN - 1) && opp && (!own || mn >= GMAX - 1);
        end else begin
            ex = (mn >= dur_of(mp) - 1);
        end
        np = mp;
        if (ex) begin
            if (PED && mdped && (mp == 0 || mp == 4)) begin
                mnxt = (mp == 0) ? 1 : 5;
                np = 8;
            end else if (mp == 8) np = 9;
            else if (mp == 9) np = mnxt;
            else np = (mp + 1) % 8;
        end
        mdns  = req_ns | (mdns & !(ex && np == 1));
        mdew  = req_ew | (mdew & !(ex && np == 5));
        mdped = PED && (ped_req | (mdped & !(ex && np == 8)));
        mn = ex ? 0 : mn + 1;
        mp = np;
    endtask

    function automatic logic [6:0] model_out();
        logic [2:0] ns, ew;
        ns = (mp == 1) ? RY : (mp == 2) ? G : (mp == 3) ? Y : R;
        ew = (mp == 5) ? RY : (mp == 6) ? G : (mp == 7) ? Y : R;
        return {ns, ew, (mp == 8)};
    endfunction

    function automatic logic [6:0] outs();
        return {rag_ns, rag_ew, walk};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk(string nm, logic [6:0] act, logic [6:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 30)
                $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       rns;
        logic       rew;
        logic [2:0] ens;
        logic [2:0] eew;
    } vec_t;

    vec_t vt[$];

    task automatic add(logic rst, logic rns, logic rew,
                       logic [2:0] ens, logic [2:0] eew, int n);
        vec_t v;
        v.rst = rst; v.rns = rns; v.rew = rew;
        v.ens = ens; v.eew = eew;
        for (int i = 0; i < n; i++) vt.push_back(v);
    endtask

    initial begin
        logic [6:0] pexp[$];
        bit found;

        // Reset, NS green at e=0, EW pulse during e=2
        add(0, 0, 0, R,  R,  2);
        add(1, 0, 0, RY, R,  2);
        add(1, 0, 0, G,  R,  3);
        add(1, 0, 1, G,  R,  1);
        add(1, 0, 0, G,  R,  4);
        add(1, 0, 0, Y,  R,  3);
        add(1, 0, 0, R,  R,  1);
        add(1, 0, 0, R,  RY, 2);
        add(1, 0, 0, R,  G,  2);

        for (int i = 0; i < vt.size(); i++) begin
            rst_n  = vt[i].rst;
            req_ns = vt[i].rns;
            req_ew = vt[i].rew;
            tick();
            chk($sformatf("vec%0d", i), outs(), {vt[i].ens, vt[i].eew, 1'b0});
        end

        // Idle junction rests on NS green
        rst_n = 0; req_ns = 0; req_ew = 0;
        tick(); tick();
        chk("idle_reset", outs(), {R, R, 1'b0});
        rst_n = 1;
        for (int c = 1; c <= 50; c++) begin
            tick();
            chk($sformatf("idle_c%0d", c), outs(),
                {(c < 3) ? RY : G, R, 1'b0});
        end

        // Own demand held extends green to GREEN_MAX
        rst_n = 0;
        tick();
        rst_n = 1; req_ns = 1;
        tick(); tick(); tick();
        chk("ext_e0", outs(), {G, R, 1'b0});
        req_ew = 1;
        for (int e = 1; e <= GMAX - 1; e++) begin
            tick();
            req_ew = 0;
            chk($sformatf("ext_e%0d", e), outs(), {G, R, 1'b0});
        end
        tick();
        chk("ext_amber", outs(), {Y, R, 1'b0});

        // Reset in EW amber aborts and clears demand
        found = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (rag_ew == Y) begin
                found = 1;
                break;
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL ew_amber_wait: got timeout want EW amber");
        end
        rst_n = 0; req_ns = 0;
        tick();
        chk("rst_amber", outs(), {R, R, 1'b0});
        rst_n = 1;
        tick(); tick();
        chk("rst_redamb", outs(), {RY, R, 1'b0});
        for (int c = 0; c < 15; c++) begin
            tick();
            chk($sformatf("rst_rest%0d", c), outs(), {G, R, 1'b0});
        end

`ifdef PED_CROSSING_EN
        // Pedestrian pulse at NS green e=1
        rst_n = 0;
        tick();
        rst_n = 1;
        tick(); tick(); tick(); tick();
        ped_req = 1;
        tick();
        ped_req = 0;
        for (int e = 3; e <= GMIN - 1; e++) tick();
        chk("ped_e7", outs(), {G, R, 1'b0});
        for (int i = 0; i < 3; i++) pexp.push_back({Y, R, 1'b0});
        pexp.push_back({R, R, 1'b0});
        for (int i = 0; i < WK; i++) pexp.push_back({R, R, 1'b1});
        pexp.push_back({R, R, 1'b0});
        pexp.push_back({R, RY, 1'b0});
        for (int i = 0; i < pexp.size(); i++) begin
            tick();
            chk($sformatf("ped%0d", i), outs(), pexp[i]);
        end
`endif

        // Random requests against the phase model
        rst_n = 0;
        tick();
        for (int c = 0; c < 10000; c++) begin
            rst_n   = ($urandom_range(0, 499) != 0);
            req_ns  = ($urandom_range(0, 5) == 0);
            req_ew  = ($urandom_range(0, 5) == 0);
            ped_req = PED && ($urandom_range(0, 39) == 0);
            tick();
            chk($sformatf("rand%0d", c), outs(), model_out());
            total++;
            if (rag_ns != R && rag_ew != R) begin
                bad++;
                if (bad <= 30)
                    $display("FAIL excl%0d: got ns=%b ew=%b want one red",
                             c, rag_ns, rag_ew);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
